ps2_key_tracker: RTL and testbench
==================================

PS2_KEY_TRACKER -- requirements
Module: ps2_key_tracker

Interface
REQ-001 Parameter CNT_W, default 8: width of press counter, legal 4..16.
REQ-002 Parameter SAT, default 0: 0 = press counter wraps at max; 1 = saturates at 2^CNT_W-1.
REQ-003 Parameter IGNORE_REPEAT, default 1: 1 = typematic repeat of held key not counted; 0 = every make byte counted.
REQ-004 clock  in  1  sole clock, all state on rising edge.
REQ-005 clrn  in  1  reset, asynchronous, active-low.
REQ-006 rx_data  in  8  head byte of ps2_keyboard FIFO.
REQ-007 rx_ready  in  1  FIFO non-empty, rx_data valid.
REQ-008 rx_overflow  in  1  FIFO overflow flag from ps2_keyboard.
REQ-009 nextdata_n  out  1  active-low pop strobe to ps2_keyboard.
REQ-010 key_valid  out  1  a key is currently held.
REQ-011 key_code  out  8  scan code of held/last key (E0 prefix stripped).
REQ-012 key_ext  out  1  held/last key was E0-extended.
REQ-013 make_pulse  out  1  one-cycle strobe, new key press accepted.
REQ-014 break_pulse  out  1  one-cycle strobe, break sequence completed.
REQ-015 press_cnt  out  CNT_W  count of accepted presses.
REQ-016 err  out  1  sticky overflow indicator.

Function
REQ-017 Handshake FSM states IDLE, POP, WAIT; IDLE->POP when rx_ready=1 sampled, byte latched on same edge.
REQ-018 nextdata_n SHALL be registered: low for exactly the one cycle in POP, high otherwise.
REQ-019 POP->WAIT->IDLE unconditionally; rx_ready not sampled in POP/WAIT, max throughput one byte per 3 cycles, no double pop.
REQ-020 Byte decode happens on the IDLE->POP edge; key_*, pulses, press_cnt visible in the POP cycle (latency 1 cycle from rx_ready sample).
REQ-021 Byte 0xE0: set ext flag only; no output change.
REQ-022 Byte 0xF0: set brk flag only; no output change.
REQ-023 Other byte b with brk=1: break_pulse=1; if key_valid and key_code==b and key_ext==ext then key_valid<=0, else held state unchanged; clear ext, brk.
REQ-024 Other byte b with brk=0, key held with same code/ext (repeat): if IGNORE_REPEAT=1 no pulse, no count; if 0 treated as new press; clear flags.
REQ-025 Other byte b with brk=0, not a repeat: key_code<=b, key_ext<=ext, key_valid<=1, make_pulse=1, press_cnt+1; clear flags.
REQ-026 press_cnt at 2^CNT_W-1 plus one press: 0 if SAT=0, hold if SAT=1.
REQ-027 Sequence E0 F0 b order only; F0 E0 b treated as E0 set then break (both flags honoured).
REQ-028 make_pulse and break_pulse never asserted in the same cycle; each high at most 1 cycle per byte.
REQ-029 rx_overflow=1 in any cycle: err<=1 (sticky), ext and brk cleared that edge; if same edge decodes a byte, decode uses cleared flags.
REQ-030 rx_ready deasserting in POP/WAIT has no effect; FSM completes sequence.

Reset
REQ-031 clrn=0 asynchronously forces: state IDLE, nextdata_n=1, key_valid=0, key_code=0x00, key_ext=0, make_pulse=0, break_pulse=0, press_cnt=0, err=0, ext=brk=0.
REQ-032 Reset mid-POP aborts the pop (nextdata_n returns high immediately); first byte after release is sampled from IDLE.
REQ-033 Only clrn clears err.

Verification
REQ-034 Bytes 1C, F0, 1C -> make_pulse once, key_code=1C, key_valid 1 then 0, break_pulse once, press_cnt=1, nextdata_n low 3 single cycles.
REQ-035 Bytes 1B,1B,1B,F0,1B with IGNORE_REPEAT=1 -> press_cnt=1; with IGNORE_REPEAT=0 -> press_cnt=3; key_valid=0 at end.
REQ-036 Bytes E0,75,E0,F0,75 -> key_code=75, key_ext=1, make then break, key_valid=0; byte 75 without E0 while ext key held -> new press.
REQ-037 CNT_W=4: 16 distinct presses -> press_cnt=0 (SAT=0) or 15 (SAT=1).
REQ-038 rx_ready held high continuously for 4 bytes -> exactly 4 pops spaced 3 cycles; rx_overflow pulse -> err=1 until clrn low.
REQ-039 clrn low during POP -> nextdata_n=1 and all outputs at reset values within the same cycle, no clock edge needed.

Source files
------------

// File: rtl/ps2_key_tracker_if.sv
// Byte handshake between the ps2_keyboard receive FIFO and its consumer.
// The FIFO side is the master: it presents the head byte and its status
// flags, and receives the active-low pop strobe back from the consumer.
interface ps2_key_tracker_if;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       rx_overflow;
  logic       nextdata_n;

  modport master (
    output rx_data,
    output rx_ready,
    output rx_overflow,
    input  nextdata_n
  );

  modport slave (
    input  rx_data,
    input  rx_ready,
    input  rx_overflow,
    output nextdata_n
  );
endinterface

// File: rtl/ps2_key_tracker.sv
// Tracks the currently held PS/2 key from a stream of set-2 scan-code bytes.
// Each byte is popped from the keyboard FIFO with a three-state handshake
// (IDLE -> POP -> WAIT) and decoded on the same edge it is sampled, so key
// state, pulses and the press counter are visible during the POP cycle.
module ps2_key_tracker #(
  parameter int CNT_W         = 8,
  parameter int SAT           = 0,
  parameter int IGNORE_REPEAT = 1
) (
  input  logic               clock,
  input  logic               clrn,
  ps2_key_tracker_if.slave   rx,
  output logic               key_valid,
  output logic [7:0]         key_code,
  output logic               key_ext,
  output logic               make_pulse,
  output logic               break_pulse,
  output logic [CNT_W-1:0]   press_cnt,
  output logic               err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t             state_q, state_d;
  logic               nextdata_n_q, nextdata_n_d;
  logic               key_valid_q, key_valid_d;
  logic [7:0]         key_code_q, key_code_d;
  logic               key_ext_q, key_ext_d;
  logic               make_q, make_d;
  logic               break_q, break_d;
  logic [CNT_W-1:0]   press_cnt_q, press_cnt_d;
  logic               err_q, err_d;
  logic               ext_q, ext_d;
  logic               brk_q, brk_d;

  // Decode helpers: overflow discards any half-received prefix before use.
  logic               accept;
  logic               ext_eff;
  logic               brk_eff;
  logic               same_key;
  logic [CNT_W-1:0]   cnt_inc;

  // State register and all registered outputs; reset is asynchronous so a
  // pop in flight is abandoned the instant clrn falls.
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      state_q      <= IDLE;
      nextdata_n_q <= 1'b1;
      key_valid_q  <= 1'b0;
      key_code_q   <= 8'h00;
      key_ext_q    <= 1'b0;
      make_q       <= 1'b0;
      break_q      <= 1'b0;
      press_cnt_q  <= '0;
      err_q        <= 1'b0;
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      nextdata_n_q <= nextdata_n_d;
      key_valid_q  <= key_valid_d;
      key_code_q   <= key_code_d;
      key_ext_q    <= key_ext_d;
      make_q       <= make_d;
      break_q      <= break_d;
      press_cnt_q  <= press_cnt_d;
      err_q        <= err_d;
      ext_q        <= ext_d;
      brk_q        <= brk_d;
    end
  end

  // Next state: rx_ready is only looked at in IDLE, POP and WAIT always run.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rx.rx_ready) state_d = POP;
      POP:     state_d = WAIT;
      WAIT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake output: pop strobe is low for the whole POP cycle only.
  always_comb begin
    nextdata_n_d = (state_d != POP);
  end

  // Byte decode, applied on the edge that moves IDLE -> POP.
  always_comb begin
    accept   = (state_q == IDLE) && rx.rx_ready;
    ext_eff  = rx.rx_overflow ? 1'b0 : ext_q;
    brk_eff  = rx.rx_overflow ? 1'b0 : brk_q;
    same_key = key_valid_q && (key_code_q == rx.rx_data) && (key_ext_q == ext_eff);
    if (press_cnt_q == CNT_MAX) begin
      cnt_inc = (SAT != 0) ? CNT_MAX : '0;
    end else begin
      cnt_inc = press_cnt_q + 1'b1;
    end

    key_valid_d = key_valid_q;
    key_code_d  = key_code_q;
    key_ext_d   = key_ext_q;
    make_d      = 1'b0;
    break_d     = 1'b0;
    press_cnt_d = press_cnt_q;
    err_d       = err_q | rx.rx_overflow;
    ext_d       = ext_eff;
    brk_d       = brk_eff;

    if (accept) begin
      if (rx.rx_data == 8'hE0) begin
        ext_d = 1'b1;
      end else if (rx.rx_data == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        if (brk_eff) begin
          // A break only releases the key if it names the held key exactly.
          break_d = 1'b1;
          if (same_key) key_valid_d = 1'b0;
        end else if (!(same_key && (IGNORE_REPEAT != 0))) begin
          key_valid_d = 1'b1;
          key_code_d  = rx.rx_data;
          key_ext_d   = ext_eff;
          make_d      = 1'b1;
          press_cnt_d = cnt_inc;
        end
      end
    end
  end

  assign rx.nextdata_n = nextdata_n_q;
  assign key_valid     = key_valid_q;
  assign key_code      = key_code_q;
  assign key_ext       = key_ext_q;
  assign make_pulse    = make_q;
  assign break_pulse   = break_q;
  assign press_cnt     = press_cnt_q;
  assign err           = err_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench for ps2_key_tracker. Three instances with different
// parameter sets share one byte stream; a reference model per instance
// pushes the expected post-decode state when a byte is driven, and a
// monitor pops and compares it in the cycle the pop strobe is low.
module tb_ps2_key_tracker;

  typedef struct packed {
    logic        valid;
    logic [7:0]  code;
    logic        ext;
    logic        make;
    logic        brk;
    logic [15:0] cnt;
    logic        err;
    logic        fe;
    logic        fb;
    logic [7:0]  b;
  } st_t;

  logic clk = 1'b0;
  logic clrn = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic rx_ready = 1'b0;
  logic rx_overflow = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  st_t ma, mb, mc;
  st_t qa[$];
  st_t qb[$];
  st_t qc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ps2_key_tracker_if ifa ();
  ps2_key_tracker_if ifb ();
  ps2_key_tracker_if ifc ();

  assign ifa.rx_data = rx_data;  assign ifa.rx_ready = rx_ready;  assign ifa.rx_overflow = rx_overflow;
  assign ifb.rx_data = rx_data;  assign ifb.rx_ready = rx_ready;  assign ifb.rx_overflow = rx_overflow;
  assign ifc.rx_data = rx_data;  assign ifc.rx_ready = rx_ready;  assign ifc.rx_overflow = rx_overflow;

  logic       va, xa, mka, bka, ea;
  logic [7:0] ca;
  logic [7:0] na;
  logic       vb, xb, mkb, bkb, eb;
  logic [7:0] cb;
  logic [3:0] nb;
  logic       vc, xc, mkc, bkc, ec;
  logic [7:0] cc;
  logic [3:0] nc;

  ps2_key_tracker #(.CNT_W(8), .SAT(0), .IGNORE_REPEAT(1)) dut_a (
    .clock(clk), .clrn(clrn), .rx(ifa.slave), .key_valid(va), .key_code(ca), .key_ext(xa),
    .make_pulse(mka), .break_pulse(bka), .press_cnt(na), .err(ea));
  ps2_key_tracker #(.CNT_W(4), .SAT(1), .IGNORE_REPEAT(0)) dut_b (
    .clock(clk), .clrn(clrn), .rx(ifb.slave), .key_valid(vb), .key_code(cb), .key_ext(xb),
    .make_pulse(mkb), .break_pulse(bkb), .press_cnt(nb), .err(eb));
  ps2_key_tracker #(.CNT_W(4), .SAT(0), .IGNORE_REPEAT(1)) dut_c (
    .clock(clk), .clrn(clrn), .rx(ifc.slave), .key_valid(vc), .key_code(cc), .key_ext(xc),
    .make_pulse(mkc), .break_pulse(bkc), .press_cnt(nc), .err(ec));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural model of one byte (or of an overflow-only cycle when pop=0).
  function automatic st_t step(input st_t s, input logic [7:0] b, input logic ovf,
                               input logic pop, input bit ign, input bit sat, input int w);
    st_t n;
    logic [15:0] mx;
    logic hit;
    n = s;
    n.make = 1'b0;
    n.brk = 1'b0;
    n.b = b;
    mx = 16'((32'd1 << w) - 1);
    if (ovf) begin
      n.err = 1'b1;
      n.fe = 1'b0;
      n.fb = 1'b0;
    end
    if (pop) begin
      hit = s.valid && (s.code == b) && (s.ext == n.fe);
      if (b == 8'hE0) n.fe = 1'b1;
      else if (b == 8'hF0) n.fb = 1'b1;
      else begin
        if (n.fb) begin
          n.brk = 1'b1;
          if (hit) n.valid = 1'b0;
        end else if (!(hit && ign)) begin
          n.valid = 1'b1;
          n.code = b;
          n.ext = n.fe;
          n.make = 1'b1;
          n.cnt = (s.cnt == mx) ? (sat ? mx : 16'd0) : s.cnt + 16'd1;
        end
        n.fe = 1'b0;
        n.fb = 1'b0;
      end
    end
    return n;
  endfunction

  task automatic push_all(input logic [7:0] b, input logic ovf);
    ma = step(ma, b, ovf, 1'b1, 1'b1, 1'b0, 8);  qa.push_back(ma);
    mb = step(mb, b, ovf, 1'b1, 1'b0, 1'b1, 4);  qb.push_back(mb);
    mc = step(mc, b, ovf, 1'b1, 1'b1, 1'b0, 4);  qc.push_back(mc);
  endtask

  task automatic cmp_out(input string p, input st_t e, input logic v, input logic [7:0] c,
                         input logic x, input logic mk, input logic bk, input logic [15:0] n,
                         input logic er);
    check({p, "_valid"}, 32'(v), 32'(e.valid));
    check({p, "_code"}, 32'(c), 32'(e.code));
    check({p, "_ext"}, 32'(x), 32'(e.ext));
    check({p, "_make"}, 32'(mk), 32'(e.make));
    check({p, "_break"}, 32'(bk), 32'(e.brk));
    check({p, "_cnt"}, 32'(n), 32'(e.cnt));
    check({p, "_err"}, 32'(er), 32'(e.err));
  endtask

  // Scoreboard monitors: compare in the pop cycle, pulses must be low elsewhere.
  always @(negedge clk) begin
    st_t e;
    if (clrn) begin
      if (ifa.nextdata_n == 1'b0) begin
        check("a_expected_avail", 32'(qa.size() != 0), 32'd1);
        if (qa.size() != 0) begin
          e = qa.pop_front();
          $display("txn byte=%02h valid=%0d code=%02h ext=%0d make=%0d brk=%0d cnt=%0d err=%0d",
                   e.b, va, ca, xa, mka, bka, na, ea);
          cmp_out("a", e, va, ca, xa, mka, bka, 16'(na), ea);
        end
      end else begin
        check("a_make_idle", 32'(mka), 32'd0);
        check("a_break_idle", 32'(bka), 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    st_t e;
    if (clrn) begin
      if (ifb.nextdata_n == 1'b0) begin
        check("b_expected_avail", 32'(qb.size() != 0), 32'd1);
        if (qb.size() != 0) begin
          e = qb.pop_front();
          cmp_out("b", e, vb, cb, xb, mkb, bkb, 16'(nb), eb);
        end
      end else begin
        check("b_make_idle", 32'(mkb), 32'd0);
        check("b_break_idle", 32'(bkb), 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    st_t e;
    if (clrn) begin
      if (ifc.nextdata_n == 1'b0) begin
        check("c_expected_avail", 32'(qc.size() != 0), 32'd1);
        if (qc.size() != 0) begin
          e = qc.pop_front();
          cmp_out("c", e, vc, cc, xc, mkc, bkc, 16'(nc), ec);
        end
      end else begin
        check("c_make_idle", 32'(mkc), 32'd0);
        check("c_break_idle", 32'(bkc), 32'd0);
      end
    end
  end

  task automatic send(input logic [7:0] b, input logic ovf);
    @(negedge clk);
    rx_data = b;
    rx_ready = 1'b1;
    rx_overflow = ovf;
    push_all(b, ovf);
    @(posedge clk); #1;
    rx_ready = 1'b0;
    rx_overflow = 1'b0;
    check("pop_low", 32'(ifa.nextdata_n), 32'd0);
    @(posedge clk); #1;
    check("pop_high", 32'(ifa.nextdata_n), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic model_reset();
    ma = '0; mb = '0; mc = '0;
    qa.delete(); qb.delete(); qc.delete();
  endtask

  task automatic reset_dut();
    @(negedge clk);
    clrn = 1'b0;
    model_reset();
    @(negedge clk);
    clrn = 1'b1;
  endtask

  task automatic check_reset_outputs(input string p);
    check({p, "_nextdata_n"}, 32'(ifa.nextdata_n), 32'd1);
    check({p, "_valid"}, 32'(va), 32'd0);
    check({p, "_code"}, 32'(ca), 32'd0);
    check({p, "_ext"}, 32'(xa), 32'd0);
    check({p, "_make"}, 32'(mka), 32'd0);
    check({p, "_break"}, 32'(bka), 32'd0);
    check({p, "_cnt"}, 32'(na), 32'd0);
    check({p, "_err"}, 32'(ea), 32'd0);
    check({p, "_b_nextdata_n"}, 32'(ifb.nextdata_n), 32'd1);
    check({p, "_b_cnt"}, 32'(nb), 32'd0);
  endtask

  initial begin
    int t;
    int pop_cyc[4];
    logic [7:0] cont_bytes[4];

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    clrn = 1'b1;

    // Press, release of one plain key.
    send(8'h1C, 1'b0); send(8'hF0, 1'b0); send(8'h1C, 1'b0);
    check("seq1_cnt", 32'(na), 32'd1);
    check("seq1_valid", 32'(va), 32'd0);

    // Typematic repeat: counted only by the IGNORE_REPEAT=0 instance.
    reset_dut();
    send(8'h1B, 1'b0); send(8'h1B, 1'b0); send(8'h1B, 1'b0);
    send(8'hF0, 1'b0); send(8'h1B, 1'b0);
    check("rep_a_cnt", 32'(na), 32'd1);
    check("rep_b_cnt", 32'(nb), 32'd3);
    check("rep_c_cnt", 32'(nc), 32'd1);
    check("rep_b_valid", 32'(vb), 32'd0);

    // Extended keys, plain key of same code, F0 E0 ordering.
    reset_dut();
    send(8'hE0, 1'b0); send(8'h75, 1'b0); send(8'hE0, 1'b0);
    send(8'hF0, 1'b0); send(8'h75, 1'b0);
    check("ext_valid_off", 32'(va), 32'd0);
    check("ext_ext", 32'(xa), 32'd1);
    send(8'hE0, 1'b0); send(8'h75, 1'b0); send(8'h75, 1'b0);
    check("plain_after_ext_cnt", 32'(na), 32'd3);
    check("plain_after_ext_ext", 32'(xa), 32'd0);
    send(8'hF0, 1'b0); send(8'hE0, 1'b0); send(8'h75, 1'b0);
    check("f0e0_still_held", 32'(va), 32'd1);
    send(8'hF0, 1'b0); send(8'h75, 1'b0);
    check("f0_release", 32'(va), 32'd0);

    // Overflow: standalone pulse clears a pending E0, then with a byte.
    send(8'hE0, 1'b0);
    @(negedge clk);
    rx_overflow = 1'b1;
    ma = step(ma, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8);
    mb = step(mb, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 4);
    mc = step(mc, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 4);
    @(negedge clk);
    rx_overflow = 1'b0;
    check("ovf_err_set", 32'(ea), 32'd1);
    send(8'h74, 1'b0);
    send(8'hE0, 1'b0); send(8'h2A, 1'b1);
    repeat (5) @(negedge clk);
    check("ovf_err_sticky", 32'(ea), 32'd1);

    // Reset asserted in the middle of a pop.
    @(negedge clk);
    rx_data = 8'h33;
    rx_ready = 1'b1;
    @(posedge clk); #1;
    rx_ready = 1'b0;
    check("midpop_low", 32'(ifa.nextdata_n), 32'd0);
    check("midpop_cnt_before", 32'(na != 0), 32'd1);
    clrn = 1'b0;
    #1;
    model_reset();
    check_reset_outputs("midpop");
    @(negedge clk);
    clrn = 1'b1;
    send(8'h44, 1'b0);
    check("after_rst_cnt", 32'(na), 32'd1);

    // Sixteen distinct presses: wrap vs saturate at CNT_W=4.
    reset_dut();
    for (int i = 0; i < 16; i++) send(8'h10 + 8'(i), 1'b0);
    check("cnt16_a", 32'(na), 32'd16);
    check("cnt16_b_sat", 32'(nb), 32'd15);
    check("cnt16_c_wrap", 32'(nc), 32'd0);

    // rx_ready held high: one pop per three cycles, four pops total.
    reset_dut();
    cont_bytes[0] = 8'h21; cont_bytes[1] = 8'h22; cont_bytes[2] = 8'h23; cont_bytes[3] = 8'h24;
    @(negedge clk);
    rx_data = cont_bytes[0];
    rx_ready = 1'b1;
    push_all(cont_bytes[0], 1'b0);
    for (int i = 0; i < 4; i++) begin
      t = 0;
      do begin
        @(posedge clk); #1;
        t++;
      end while (ifa.nextdata_n && t < 10);
      check("cont_pop_seen", 32'(ifa.nextdata_n), 32'd0);
      pop_cyc[i] = cyc;
      if (i < 3) begin
        rx_data = cont_bytes[i+1];
        push_all(cont_bytes[i+1], 1'b0);
      end else begin
        rx_ready = 1'b0;
      end
    end
    for (int i = 1; i < 4; i++) check("cont_spacing", 32'(pop_cyc[i] - pop_cyc[i-1]), 32'd3);
    repeat (8) @(negedge clk);
    check("cont_cnt", 32'(na), 32'd4);
    check("queue_a_drained", 32'(qa.size()), 32'd0);
    check("queue_b_drained", 32'(qb.size()), 32'd0);
    check("queue_c_drained", 32'(qc.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
